// File: rtl/i2s_stereo_rx_if.sv
// Bundles the synchronized I2S serial lines and the stereo sample outputs of i2s_stereo_rx.
// The master side drives the serial stream; the slave side is the receiver.
interface i2s_stereo_rx_if #(
   parameter int WIDTH = 16
);
   logic                    serial_clk_sync;
   logic                    lr_clk_sync;
   logic                    serial_in_sync;
   logic signed [WIDTH-1:0] left_out;
   logic signed [WIDTH-1:0] right_out;
   logic signed [WIDTH-1:0] mono_out;
   logic                    data_rdy;
   logic                    frame_err;

   modport master (
      output serial_clk_sync, lr_clk_sync, serial_in_sync,
      input  left_out, right_out, mono_out, data_rdy, frame_err
   );

   modport slave (
      input  serial_clk_sync, lr_clk_sync, serial_in_sync,
      output left_out, right_out, mono_out, data_rdy, frame_err
   );
endinterface

// File: rtl/i2s_stereo_rx.sv
// I2S stereo deserialiser: pairs left/right WIDTH-bit words and strobes data_rdy or frame_err.
// Optional feature macro I2S_MONO_SUM_EN adds a registered (L+R)/2 output on mono_out.
module i2s_stereo_rx #(
   parameter int WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   i2s_stereo_rx_if.slave bus_io
);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0]        shift_q, shift_d;
   logic                    slot_q, slot_d;
   logic signed [WIDTH-1:0] left_hold_q, left_hold_d;
   logic                    left_valid_q, left_valid_d;
   logic signed [WIDTH-1:0] left_out_q, left_out_d;
   logic signed [WIDTH-1:0] right_out_q, right_out_d;
   logic                    data_rdy_q, data_rdy_d;
   logic                    frame_err_q, frame_err_d;
   logic                    sclk_q;
   logic                    lr_q, lr_d;
   logic                    bck_edge;
   logic                    lr_trans;
   logic [WIDTH-1:0]        word_c;

`ifdef I2S_MONO_SUM_EN
   logic signed [WIDTH-1:0] mono_q, mono_d;

   // Sign-extend to WIDTH+1 bits so the sum cannot wrap; dropping the LSB floors toward -inf.
   function automatic logic signed [WIDTH-1:0] mono_sum(input logic signed [WIDTH-1:0] l,
                                                         input logic signed [WIDTH-1:0] r);
      logic signed [WIDTH:0] s;
      s = $signed({l[WIDTH-1], l}) + $signed({r[WIDTH-1], r});
      return s[WIDTH:1];
   endfunction
`endif

   assign bck_edge = bus_io.serial_clk_sync & ~sclk_q;
   assign lr_trans = bck_edge & (bus_io.lr_clk_sync != lr_q);
   assign word_c   = {shift_q[WIDTH-2:0], bus_io.serial_in_sync};

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      slot_d       = slot_q;
      left_hold_d  = left_hold_q;
      left_valid_d = left_valid_q;
      left_out_d   = left_out_q;
      right_out_d  = right_out_q;
      data_rdy_d   = 1'b0;
      frame_err_d  = 1'b0;
      lr_d         = lr_q;
`ifdef I2S_MONO_SUM_EN
      mono_d       = mono_q;
`endif
      if (bck_edge) begin
         lr_d = bus_io.lr_clk_sync;
         // The bit sampled on a transition edge is the I2S delay bit and is never shifted in.
         if (lr_trans) begin
            if (state_q == S_SHIFT) begin
               frame_err_d  = 1'b1;
               left_valid_d = 1'b0;
            end
            state_d   = S_SHIFT;
            bit_cnt_d = '0;
            slot_d    = bus_io.lr_clk_sync;
         end else if (state_q == S_SHIFT) begin
            shift_d = word_c;
            if (bit_cnt_q == LAST_BIT) begin
               state_d = S_WAIT;
               if (!slot_q) begin
                  left_hold_d  = $signed(word_c);
                  left_valid_d = 1'b1;
               end else if (left_valid_q) begin
                  left_out_d   = left_hold_q;
                  right_out_d  = $signed(word_c);
                  data_rdy_d   = 1'b1;
                  left_valid_d = 1'b0;
`ifdef I2S_MONO_SUM_EN
                  mono_d       = mono_sum(left_hold_q, $signed(word_c));
`endif
               end
            end else begin
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         slot_q       <= 1'b0;
         left_hold_q  <= '0;
         left_valid_q <= 1'b0;
         left_out_q   <= '0;
         right_out_q  <= '0;
         data_rdy_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         sclk_q       <= 1'b0;
         lr_q         <= 1'b0;
`ifdef I2S_MONO_SUM_EN
         mono_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         slot_q       <= slot_d;
         left_hold_q  <= left_hold_d;
         left_valid_q <= left_valid_d;
         left_out_q   <= left_out_d;
         right_out_q  <= right_out_d;
         data_rdy_q   <= data_rdy_d;
         frame_err_q  <= frame_err_d;
         sclk_q       <= bus_io.serial_clk_sync;
         lr_q         <= lr_d;
`ifdef I2S_MONO_SUM_EN
         mono_q       <= mono_d;
`endif
      end
   end

   assign bus_io.left_out  = left_out_q;
   assign bus_io.right_out = right_out_q;
   assign bus_io.data_rdy  = data_rdy_q;
   assign bus_io.frame_err = frame_err_q;
`ifdef I2S_MONO_SUM_EN
   assign bus_io.mono_out  = mono_q;
`else
   assign bus_io.mono_out  = '0;
`endif
endmodule

// File: tb/tb_i2s_stereo_rx.sv
// Directed bench for i2s_stereo_rx: clk = 8x BCK, hand-computed left/right/mono expectations.
module tb_i2s_stereo_rx;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   rdy_cnt;
   int   err_cnt;
   int   both_cnt;
   int   base_rdy;

   i2s_stereo_rx_if #(.WIDTH(16)) bus ();

   i2s_stereo_rx #(.WIDTH(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (bus.data_rdy) rdy_cnt++;
         if (bus.frame_err) err_cnt++;
         if (bus.data_rdy && bus.frame_err) both_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One BCK period: data and LR change with BCK low, rising edge after 4 clk.
   task automatic drive_bit(input logic lr_v, input logic d, output logic r1, output logic r2);
      bus.serial_clk_sync = 1'b0;
      bus.lr_clk_sync     = lr_v;
      bus.serial_in_sync  = d;
      repeat (4) @(negedge clk);
      bus.serial_clk_sync = 1'b1;
      @(negedge clk);
      r1 = bus.data_rdy;
      @(negedge clk);
      r2 = bus.data_rdy;
      repeat (2) @(negedge clk);
   endtask

   task automatic slot(input logic lr_v, input logic [15:0] w, input int nd, input int ntr,
                       input int exp_rdy);
      logic r1, r2;
      drive_bit(lr_v, 1'b1, r1, r2);
      for (int i = 0; i < nd; i++) drive_bit(lr_v, w[15-i], r1, r2);
      if (exp_rdy >= 0) begin
         check("rdy_after_last_bit", {31'd0, r1}, {31'd0, exp_rdy[0]});
         if (exp_rdy == 1) check("rdy_one_cycle", {31'd0, r2}, 32'd0);
      end
      for (int i = 0; i < ntr; i++) drive_bit(lr_v, 1'b0, r1, r2);
   endtask

   task automatic frame(input logic [15:0] l, input logic [15:0] r, input int ndl, input int ntr,
                        input int exp_rdy);
      slot(1'b0, l, ndl, ntr, -1);
      slot(1'b1, r, 16, ntr, exp_rdy);
   endtask

   task automatic check_pair(input string tag, input logic [15:0] l, input logic [15:0] r,
                             input logic [15:0] m);
      check({tag, "_left"}, {16'd0, $unsigned(bus.left_out)}, {16'd0, l});
      check({tag, "_right"}, {16'd0, $unsigned(bus.right_out)}, {16'd0, r});
`ifdef I2S_MONO_SUM_EN
      check({tag, "_mono"}, {16'd0, $unsigned(bus.mono_out)}, {16'd0, m});
`else
      if (m == m) check({tag, "_mono"}, {16'd0, $unsigned(bus.mono_out)}, 32'd0);
`endif
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_left"}, {16'd0, $unsigned(bus.left_out)}, 32'd0);
      check({tag, "_right"}, {16'd0, $unsigned(bus.right_out)}, 32'd0);
      check({tag, "_mono"}, {16'd0, $unsigned(bus.mono_out)}, 32'd0);
      check({tag, "_rdy"}, {31'd0, bus.data_rdy}, 32'd0);
      check({tag, "_err"}, {31'd0, bus.frame_err}, 32'd0);
   endtask

   initial begin
      logic r1, r2;
      n_checks = 0;
      n_fail   = 0;
      rdy_cnt  = 0;
      err_cnt  = 0;
      both_cnt = 0;
      rst = 1'b1;
      bus.serial_clk_sync = 1'b0;
      bus.lr_clk_sync     = 1'b0;
      bus.serial_in_sync  = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      // Start mid-frame: partial left (no transition) then an unpaired right slot.
      for (int i = 0; i < 8; i++) drive_bit(1'b0, 1'b1, r1, r2);
      slot(1'b1, 16'hFFFF, 16, 0, 0);
      check("partial_frame_rdy_cnt", rdy_cnt, 0);

      frame(16'h1234, 16'hABCD, 16, 0, 1);
      check_pair("frame1", 16'h1234, 16'hABCD, 16'hDF00);
      frame(16'h1234, 16'hABCD, 16, 0, 1);
      check_pair("frame2", 16'h1234, 16'hABCD, 16'hDF00);
      check("clean_rdy_cnt", rdy_cnt, 2);
      check("clean_err_cnt", err_cnt, 0);

      // Left slot truncated to 10 bits.
      slot(1'b0, 16'h5555, 10, 0, -1);
      slot(1'b1, 16'h0F0F, 16, 0, 0);
      check("trunc_err_cnt", err_cnt, 1);
      check("trunc_rdy_cnt", rdy_cnt, 2);
      check_pair("trunc_hold", 16'h1234, 16'hABCD, 16'hDF00);

      frame(16'h7FFF, 16'h7FFF, 16, 0, 1);
      check_pair("maxpos", 16'h7FFF, 16'h7FFF, 16'h7FFF);
      frame(16'h8000, 16'h0001, 16, 0, 1);
      check_pair("minneg", 16'h8000, 16'h0001, 16'hC000);

      // 32-bit slots: 16 data bits plus trailing zeros.
      frame(16'hA5C3, 16'h3C5A, 16, 15, 1);
      check_pair("slot32", 16'hA5C3, 16'h3C5A, 16'hF10E);
      check("slot32_err_cnt", err_cnt, 1);

      // LR stuck low for three further slots.
      base_rdy = rdy_cnt;
      slot(1'b0, 16'h1111, 16, 0, -1);
      for (int i = 0; i < 51; i++) drive_bit(1'b0, 1'b1, r1, r2);
      check("stuck_rdy_cnt", rdy_cnt, base_rdy);
      check("stuck_err_cnt", err_cnt, 1);
      slot(1'b1, 16'h2222, 16, 0, -1);
      frame(16'h0100, 16'h0300, 16, 0, 1);
      check_pair("resume", 16'h0100, 16'h0300, 16'h0200);

      // Reset in the middle of a right slot.
      slot(1'b0, 16'h2222, 16, 0, -1);
      slot(1'b1, 16'h3333, 8, 0, -1);
      rst = 1'b1;
      @(negedge clk);
      check_zero("midreset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      base_rdy = rdy_cnt;
      for (int i = 0; i < 8; i++) drive_bit(1'b1, 1'b0, r1, r2);
      check("post_reset_no_rdy", rdy_cnt, base_rdy);
      frame(16'h4321, 16'h8765, 16, 0, 1);
      check_pair("post_reset", 16'h4321, 16'h8765, 16'hE543);
      check("post_reset_rdy_cnt", rdy_cnt, base_rdy + 1);

      check("rdy_err_overlap", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
